// File: rtl/qspi_feeder.sv
// rtl/qspi_feeder.sv - byte FIFO feeding a QSPI nibble parallelizer with key-burst programming
module qspi_feeder #(
  parameter int FIFO_DEPTH  = 16,
  parameter int KEY_NIBBLES = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    host_data,
  input  logic                          host_valid,
  output logic                          host_ready,
  input  logic                          cmd_prog,
  input  logic                          qspi_ready,
  output logic [3:0]                    qspi_data,
  output logic                          qspi_sending,
  output logic                          prog,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CW        = (KEY_NIBBLES > 2) ? $clog2(KEY_NIBBLES) : 1;
  localparam int KEY_BYTES = KEY_NIBBLES / 2;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   KEY_CNT  = (AW+1)'(KEY_BYTES);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [CW-1:0] NIB_LAST = CW'(KEY_NIBBLES - 1);
  localparam logic [CW-1:0] NIB_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PROG,
    S_WAIT_RDY,
    S_KEY,
    S_DATA
  } state_t;

  // Reset is applied asynchronously but released only on a clock edge,
  // so no flop sees a deassertion racing the active edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  // two-stage release synchroniser for the internal reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [7:0]    rd_byte;
  logic          push, pop;

  assign host_ready = (count_q != FULL_CNT);
  assign push       = host_valid && host_ready;
  assign rd_byte    = mem_q[rd_ptr_q];

  // byte storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= host_data;
  end

  // pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  state_t        state_q, state_d;
  logic [CW-1:0] nib_q, nib_d;
  logic          pend_q, pend_d;
  logic [3:0]    data_q, data_d;
  logic          send_q, send_d;
  logic          prog_q, prog_d;

  // state, nibble counter, pending-program flag and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      nib_q   <= '0;
      pend_q  <= 1'b0;
      data_q  <= 4'h0;
      send_q  <= 1'b0;
      prog_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      send_q  <= send_d;
      prog_q  <= prog_d;
    end
  end

  // Next state and next outputs; each state's action shows on the pins one
  // cycle later. nib_q[0] selects high (0) or low (1) nibble of the head byte.
  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    pend_d  = pend_q;
    data_d  = 4'h0;
    send_d  = 1'b0;
    prog_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_prog) begin
          state_d = S_PROG;
        end else if ((count_q != '0) && qspi_ready) begin
          state_d = S_DATA;
          nib_d   = '0;
        end
      end
      S_PROG: begin
        prog_d  = 1'b1;
        state_d = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        if (qspi_ready && (count_q >= KEY_CNT)) begin
          state_d = S_KEY;
          nib_d   = '0;
        end
      end
      S_KEY: begin
        // the burst ignores qspi_ready; enough bytes were buffered on entry
        send_d = 1'b1;
        data_d = nib_q[0] ? rd_byte[3:0] : rd_byte[7:4];
        pop    = nib_q[0];
        if (nib_q == NIB_LAST) begin
          state_d = S_IDLE;
          nib_d   = '0;
        end else begin
          nib_d = nib_q + 1'b1;
        end
      end
      S_DATA: begin
        send_d = 1'b1;
        if (cmd_prog) pend_d = 1'b1;
        if (!nib_q[0]) begin
          data_d = rd_byte[7:4];
          nib_d  = NIB_ONE;
        end else begin
          // byte boundary: the only place a DATA run may stop or divert
          data_d = rd_byte[3:0];
          pop    = 1'b1;
          nib_d  = '0;
          if (pend_q || cmd_prog) begin
            state_d = S_PROG;
            pend_d  = 1'b0;
          end else if (!(qspi_ready && ((count_q > ONE_CNT) || push))) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign qspi_data    = data_q;
  assign qspi_sending = send_q;
  assign prog         = prog_q;
  assign fifo_count   = count_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_qspi_feeder.sv
// tb/tb_qspi_feeder.sv - self-checking bench for qspi_feeder
module tb_qspi_feeder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] host_data = 8'h00;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic       cmd_prog = 1'b0;
  logic       qspi_ready = 1'b0;
  logic [3:0] qspi_data;
  logic       qspi_sending;
  logic       prog;
  logic [4:0] fifo_count;
  logic       busy;

  qspi_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .host_data    (host_data),
    .host_valid   (host_valid),
    .host_ready   (host_ready),
    .cmd_prog     (cmd_prog),
    .qspi_ready   (qspi_ready),
    .qspi_data    (qspi_data),
    .qspi_sending (qspi_sending),
    .prog         (prog),
    .fifo_count   (fifo_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: nibble stream owed to the parallelizer, in push order
  logic [3:0] exp_nib[$];
  int pushed, ne, cur_run, last_run, prog_cnt, ord_err, inv_err, zero_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: record an accepted byte, then sample outputs 1ns after the edge
  task automatic step();
    logic       acc;
    logic [7:0] b;
    acc = host_valid && host_ready;
    b   = host_data;
    @(posedge clk);
    #1;
    if (acc) begin
      exp_nib.push_back(b[7:4]);
      exp_nib.push_back(b[3:0]);
      pushed++;
    end
    if (qspi_sending) begin
      ne++;
      cur_run++;
      if (exp_nib.size() == 0) ord_err++;
      else if (exp_nib.pop_front() !== qspi_data) ord_err++;
    end else begin
      if (cur_run != 0) last_run = cur_run;
      cur_run = 0;
      if (qspi_data !== 4'h0) zero_err++;
    end
    if (prog) prog_cnt++;
    // bytes held = bytes accepted - bytes whose low nibble has gone out
    if (int'(fifo_count) != pushed - ne / 2) inv_err++;
  endtask

  task automatic clear_model();
    exp_nib.delete();
    pushed = 0; ne = 0; cur_run = 0; last_run = 0; prog_cnt = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    host_data  = b;
    host_valid = 1'b1;
    step();
    host_valid = 1'b0;
  endtask

  initial begin
    int ne0, acc_cnt, guard;
    logic done;
    clear_model();
    ord_err = 0; inv_err = 0; zero_err = 0;

    // reset values, visible before any clock edge
    #2 reset = 1'b0;
    #1;
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_host_ready", host_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sending", qspi_sending, 0);
    chk("rst_prog", prog, 0);
    repeat (3) step();
    reset = 1'b1;
    repeat (4) step();

    // single byte 0xA5: latency N+2, then A, 5, idle
    qspi_ready = 1'b1;
    push_byte(8'hA5);
    chk("lat_edgeN_send", qspi_sending, 0);
    step();
    chk("lat_edgeN1_send", qspi_sending, 0);
    step();
    chk("lat_edgeN2_send", qspi_sending, 1);
    chk("a5_hi", qspi_data, 4'hA);
    step();
    chk("a5_lo_send", qspi_sending, 1);
    chk("a5_lo", qspi_data, 4'h5);
    step();
    chk("a5_end_send", qspi_sending, 0);
    chk("a5_end_count", fifo_count, 0);
    chk("a5_end_busy", busy, 0);

    // key burst: 8 bytes then cmd_prog, must hold in WAIT_RDY until byte 16
    qspi_ready = 1'b0;
    last_run = 0; prog_cnt = 0;
    for (int i = 0; i < 8; i++) push_byte(8'(i));
    cmd_prog = 1'b1;
    step();
    cmd_prog = 1'b0;
    qspi_ready = 1'b1;
    ne0 = ne;
    repeat (10) step();
    chk("wait_no_send", ne, ne0);
    chk("wait_busy", busy, 1);
    chk("prog_pulse_len", prog_cnt, 1);
    for (int i = 8; i < 16; i++) push_byte(8'(i));
    chk("wait_until_16", ne, ne0);
    step();
    qspi_ready = 1'b0;
    repeat (40) step();
    chk("key_run_len", last_run, 32);
    chk("key_order", ord_err, 0);
    chk("key_end_count", fifo_count, 0);
    chk("key_end_busy", busy, 0);
    chk("key_prog_total", prog_cnt, 1);

    // fill to full, rejected push, then randomized streaming with wrap
    for (int i = 0; i < 16; i++) push_byte(8'($urandom));
    chk("full_ready", host_ready, 0);
    chk("full_count", fifo_count, 16);
    host_data = 8'hEE; host_valid = 1'b1;
    step(); step();
    host_valid = 1'b0;
    chk("full_no_push", fifo_count, 16);
    acc_cnt = 16;
    guard = 0;
    while (acc_cnt < 40 && guard < 2000) begin
      qspi_ready = ($urandom_range(0, 3) != 0);
      if (host_valid && host_ready) acc_cnt++;
      host_valid = (acc_cnt < 40) && ($urandom_range(0, 2) != 0);
      host_data  = 8'($urandom);
      if (host_valid && host_ready && acc_cnt == 39) begin
        step();
        acc_cnt++;
        host_valid = 1'b0;
      end else begin
        step();
      end
      guard++;
    end
    host_valid = 1'b0;
    chk("rand_pushed_40", acc_cnt >= 40, 1);
    qspi_ready = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      step();
      done = (fifo_count == 0) && !busy && !qspi_sending;
    end
    chk("rand_drained", done, 1);
    chk("rand_order", ord_err, 0);
    chk("rand_queue_empty", exp_nib.size(), 0);

    // qspi_ready dropped while the high nibble is out: low nibble still follows
    qspi_ready = 1'b0;
    push_byte(8'h3C);
    push_byte(8'h7E);
    qspi_ready = 1'b1;
    for (int i = 0; i < 10 && !qspi_sending; i++) step();
    chk("drop_hi", qspi_data, 4'h3);
    qspi_ready = 1'b0;
    step();
    chk("drop_lo_send", qspi_sending, 1);
    chk("drop_lo", qspi_data, 4'hC);
    step();
    chk("drop_stop", qspi_sending, 0);
    repeat (5) step();
    chk("drop_held_count", fifo_count, 1);
    chk("drop_run", last_run, 2);
    qspi_ready = 1'b1;
    repeat (8) step();
    chk("resume_run", last_run, 2);
    chk("resume_count", fifo_count, 0);
    chk("resume_order", ord_err, 0);

    // reset at nibble 10 of a key burst
    qspi_ready = 1'b0;
    for (int i = 0; i < 16; i++) push_byte(8'($urandom));
    cmd_prog = 1'b1;
    step();
    cmd_prog = 1'b0;
    qspi_ready = 1'b1;
    for (int i = 0; i < 100 && cur_run != 10; i++) step();
    chk("mid_key_at_10", cur_run, 10);
    #2 reset = 1'b0;
    #1;
    chk("async_sending", qspi_sending, 0);
    chk("async_data", qspi_data, 0);
    chk("async_prog", prog, 0);
    chk("async_busy", busy, 0);
    chk("async_count", fifo_count, 0);
    chk("async_ready", host_ready, 1);
    clear_model();
    repeat (3) step();
    reset = 1'b1;
    repeat (30) step();
    chk("post_rst_no_send", ne, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_count", fifo_count, 0);

    chk("idle_data_zero", zero_err, 0);
    chk("count_invariant", inv_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
